lsu_dmem: RTL
=============

Name: lsu_dmem

Overview:
- Load/store responder on the data side of the single-cycle/multi-cycle RISC-V datapath.
- Consumes the memory controls produced by instruction decode: write enable, access size (i_data_type) and load signedness (i_unsigned).
- Performs byte/half/word accesses to an internal word-organised data memory, with byte-lane steering, sign/zero extension of loads, and alignment/range checking.
- Handshakes with the core through a req/ready/done protocol with fixed latency.

Parameters:
- DEPTH_WORDS, 2048, number of 32-bit words in data memory (power of two); byte address space is 0 .. 4*DEPTH_WORDS-1.
- AW, $clog2(DEPTH_WORDS), word-index width, derived; index = i_addr[AW+1:2].

Ports:
- i_clk  in  1  clock, all state updates on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_req  in  1  access request; accepted only when o_ready=1.
- i_wren  in  1  1=store, 0=load (decode mem_wren).
- i_data_type  in  2  access size: 00 word, 01 half, 10 byte, 11 reserved.
- i_unsigned  in  1  load zero-extend when 1, sign-extend when 0; ignored for stores.
- i_addr  in  32  byte address (ALU result).
- i_wdata  in  32  store data; the low byte/half is used for sub-word stores.
- o_ready  out  1  high only in IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  valid with o_done: misaligned, out-of-range or reserved-size access.
- o_rdata  out  32  extended load result; valid with o_done and held until the next successful load.

Behaviour:
- Reset (async, any state): state=IDLE, o_ready=1, o_done=0, o_err=0, o_rdata=0. Memory contents are not reset.
- FSM: IDLE -> ACCESS -> DONE -> IDLE, one cycle per state, no stalls.
- IDLE:
  - o_ready=1.
  - If i_req=1 at an edge, capture i_wren, i_data_type, i_unsigned, i_addr, i_wdata into request registers and go to ACCESS.
  - If i_req=0, stay in IDLE.
- ACCESS:
  - o_ready=0; i_req is ignored and never queued.
  - Compute err = (type==11) | (type==01 & addr[0]) | (type==00 & addr[1:0]!=0) | (addr >= 4*DEPTH_WORDS).
  - If err: no memory write, o_rdata unchanged, latch o_err=1.
  - Else store: memory word written at the ACCESS->DONE edge with byte enables.
    - byte: lane addr[1:0] <= wdata[7:0].
    - half: lanes {addr[1],1},{addr[1],0} <= wdata[15:0].
    - word: all lanes <= wdata.
    - Other lanes are preserved.
  - Else load:
    - Memory read is combinational (async-read array).
    - Select byte at addr[1:0], or half at addr[1], or the full word.
    - Extend to 32 bits per i_unsigned and register into o_rdata at the ACCESS->DONE edge.
- DONE: o_done=1 for exactly one cycle; o_err valid this cycle only; then go to IDLE. o_err=0 outside DONE.
- Latency: request sampled at edge E -> o_done high in cycle following edge E+1. Minimum request spacing is 3 cycles; o_ready is low in ACCESS and DONE.
- Store/error completions leave o_rdata holding the last load value.
- Reset mid-operation:
  - Reset during ACCESS suppresses the pending write, because the write is gated by the state register and reset wins.
  - Reset during DONE drops the o_done pulse.
- Highest legal byte address 4*DEPTH_WORDS-1 is in range; no wrap-around of out-of-range addresses onto low memory.
- Store of type 10/01 ignores i_unsigned; load of type 00 ignores i_unsigned.

Test Plan:
- Reset, no requests -> o_ready=1, o_done=0, o_err=0, o_rdata=0x00000000; assert i_reset mid-idle and the outputs are unchanged.
- Store word 0xDEADBEEF @0x10 (req at edge E) -> o_done in cycle after E+1, o_err=0. Load word @0x10 -> o_rdata=0xDEADBEEF with o_done, exactly 2 edges after acceptance.
- Store byte wdata=0x00000080 @0x13, then:
  - load byte signed @0x13 -> 0xFFFFFF80;
  - load byte unsigned @0x13 -> 0x00000080;
  - load word @0x10 -> 0x80ADBEEF;
  - load half signed @0x10 -> 0xFFFFBEEF;
  - load half unsigned @0x12 -> 0x000080AD.
- Store half @0x11 and store word @0x12 -> o_err=1 with o_done, o_rdata unchanged. Load word @0x10 still returns 0x80ADBEEF. Type 11 @0x0 -> o_err=1.
- DEPTH_WORDS=2048:
  - load word @0x00002000 -> o_err=1;
  - load word @0x00001FFC -> o_err=0;
  - store word @0x2000 does not alter word 0.
- Store word 0x12345678 @0x20, assert i_reset during ACCESS -> o_ready=1 immediately, no o_done. Later load @0x20 returns the prior contents. i_req held high during ACCESS/DONE of another request -> not accepted until IDLE.

Source files
------------

// File: rtl/lsu_dmem_if.sv
// Core-side load/store request bus for the data memory responder.
// The core drives the request fields; the responder returns ready/done/err/rdata.
interface lsu_dmem_if;
  logic        i_req;
  logic        i_wren;
  logic [1:0]  i_data_type;
  logic        i_unsigned;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_ready;
  logic        o_done;
  logic        o_err;
  logic [31:0] o_rdata;

  modport master (
    output i_req, i_wren, i_data_type, i_unsigned, i_addr, i_wdata,
    input  o_ready, o_done, o_err, o_rdata
  );

  modport slave (
    input  i_req, i_wren, i_data_type, i_unsigned, i_addr, i_wdata,
    output o_ready, o_done, o_err, o_rdata
  );
endinterface

// File: rtl/lsu_dmem.sv
// Load/store responder with an internal word-organised data memory.
// Fixed three-state handshake: IDLE accepts, ACCESS reads/writes, DONE pulses.
// Sub-word stores use byte enables; sub-word loads are sign/zero extended.
module lsu_dmem #(
  parameter int DEPTH_WORDS = 2048
) (
  input  logic      i_clk,
  input  logic      i_reset,
  lsu_dmem_if.slave bus
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] BYTE_LIMIT = 32'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Access size encodings from instruction decode.
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  state_t state;

  // Captured request, valid while the FSM is outside IDLE.
  logic        wren_p0;
  logic [1:0]  type_p0;
  logic        uns_p0;
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;

  // Registered outputs.
  logic        ready_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic          acc_err;
  logic [31:0]   rd_word;
  logic [3:0]    be;
  logic [31:0]   wr_lanes;
  logic          do_write;

  // Reserved size, misalignment for the access size, or beyond the array.
  // The full 32-bit compare keeps high addresses from aliasing onto low memory.
  function automatic logic access_err(input logic [1:0] t, input logic [31:0] a);
    logic bad_size;
    logic misalign;
    logic out_range;
    bad_size  = (t == 2'b11);
    misalign  = ((t == SZ_HALF) && a[0]) || ((t == SZ_WORD) && (a[1:0] != 2'b00));
    out_range = (a >= BYTE_LIMIT);
    return bad_size || misalign || out_range;
  endfunction

  // Pick the addressed byte/half/word out of the memory word and extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  t,
                                              input logic [1:0]  o,
                                              input logic        uns);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] ext_s;
    logic        [31:0] res;
    b   = word[8*o +: 8];
    h   = o[1] ? word[31:16] : word[15:0];
    b_s = signed'(b);
    h_s = signed'(h);
    case (t)
      SZ_BYTE: begin
        ext_s = b_s;
        res   = uns ? {24'd0, b} : ext_s;
      end
      SZ_HALF: begin
        ext_s = h_s;
        res   = uns ? {16'd0, h} : ext_s;
      end
      default: res = word;
    endcase
    return res;
  endfunction

  // Byte lanes touched by a store of the given size at the given offset.
  function automatic logic [3:0] byte_enables(input logic [1:0] t, input logic [1:0] o);
    logic [3:0] en;
    case (t)
      SZ_BYTE: en = 4'b0001 << o;
      SZ_HALF: en = o[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: en = 4'b1111;
      default: en = 4'b0000;
    endcase
    return en;
  endfunction

  // Replicate the low byte/half across all lanes so the enables alone steer it.
  function automatic logic [31:0] store_lanes(input logic [1:0] t, input logic [31:0] d);
    logic [31:0] v;
    case (t)
      SZ_BYTE: v = {4{d[7:0]}};
      SZ_HALF: v = {2{d[15:0]}};
      default: v = d;
    endcase
    return v;
  endfunction

  // ACCESS-stage decode of the captured request against the async-read array.
  always_comb begin
    idx      = addr_p0[AW+1:2];
    off      = addr_p0[1:0];
    acc_err  = access_err(type_p0, addr_p0);
    rd_word  = mem[idx];
    be       = byte_enables(type_p0, off);
    wr_lanes = store_lanes(type_p0, wdata_p0);
    do_write = (state == ACCESS) && wren_p0 && !acc_err;
  end

  // Request capture at acceptance; data path only, no reset needed.
  always_ff @(posedge i_clk) begin
    if ((state == IDLE) && bus.i_req) begin
      wren_p0  <= bus.i_wren;
      type_p0  <= bus.i_data_type;
      uns_p0   <= bus.i_unsigned;
      addr_p0  <= bus.i_addr;
      wdata_p0 <= bus.i_wdata;
    end
  end

  // Byte-enabled store at the ACCESS->DONE edge; an async reset clears the
  // state register first, so an interrupted ACCESS never writes.
  always_ff @(posedge i_clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wr_lanes[8*b +: 8];
      end
    end
  end

  // Handshake FSM with registered ready/done/err and the held load result.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (bus.i_req) begin
            state   <= ACCESS;
            ready_q <= 1'b0;
          end
        end
        ACCESS: begin
          state  <= DONE;
          done_q <= 1'b1;
          err_q  <= acc_err;
          if (!acc_err && !wren_p0) rdata_q <= load_extend(rd_word, type_p0, off, uns_p0);
        end
        DONE: begin
          state   <= IDLE;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.o_ready = ready_q;
  assign bus.o_done  = done_q;
  assign bus.o_err   = err_q;
  assign bus.o_rdata = rdata_q;

endmodule
